// File: rtl/wisc_alu_pkg.sv
// Shared definitions for the WISC ALU and its multiply sequencer.
//   WISC_WIDTH : datapath width of the ALU (16)
//   ALU_*      : Alu_Ctrl opcodes understood by the ALU
//   SEQ_*      : multiply sequencer state encoding
package wisc_alu_pkg;

   localparam int WISC_WIDTH = 16;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_NAND = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1100;
   localparam logic [3:0] ALU_SRL  = 4'b1110;
   localparam logic [3:0] ALU_SRA  = 4'b1111;

   localparam logic [1:0] SEQ_IDLE = 2'd0;
   localparam logic [1:0] SEQ_ADD  = 2'd1;
   localparam logic [1:0] SEQ_SHF  = 2'd2;
   localparam logic [1:0] SEQ_DONE = 2'd3;

endpackage

// File: rtl/alu_mul_seq_alu_port_mux.sv
// Combinational 2:1 select of the ALU request {a, b, ctrl}.
//   ex_a/ex_b/ex_ctrl    : request from the EX stage
//   seq_a/seq_b/seq_ctrl : request from the multiply sequencer
//   sel_seq              : 1 selects the sequencer (it owns the ALU)
//   alu_a/alu_b/alu_ctrl : drive the ALU A, B and Alu_Ctrl ports
module alu_mul_seq_alu_port_mux
   import wisc_alu_pkg::*;
#(
   parameter int WIDTH = WISC_WIDTH
) (
   input  logic [WIDTH-1:0] ex_a,
   input  logic [WIDTH-1:0] ex_b,
   input  logic [3:0]       ex_ctrl,
   input  logic [WIDTH-1:0] seq_a,
   input  logic [WIDTH-1:0] seq_b,
   input  logic [3:0]       seq_ctrl,
   input  logic             sel_seq,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl
);

   always_comb begin
      if (sel_seq) begin
         alu_a    = seq_a;
         alu_b    = seq_b;
         alu_ctrl = seq_ctrl;
      end else begin
         alu_a    = ex_a;
         alu_b    = ex_b;
         alu_ctrl = ex_ctrl;
      end
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Multiply sequencer and ALU-port arbiter for the 16-bit WISC ALU.
// Runs unsigned 16x16 multiplies (low 16 bits kept) as shift-and-add passes
// through the shared ALU; otherwise passes the EX request straight through.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, mul_a, mul_b : multiply request and operands (taken in IDLE only)
//   busy, done          : sequencer active / one-cycle completion pulse
//   product, mul_z/n    : registered result and its zero / sign flags
//   ex_a/ex_b/ex_ctrl   : EX-stage ALU request; ex_flag_we its flag write
//   ex_stall            : EX must hold while the sequencer owns the ALU
//   alu_a/alu_b/ctrl    : to the ALU; alu_result from the ALU
//   flag_we             : flag write enable, suppressed while stalled
//
// state | meaning
// IDLE  | ALU follows EX; waiting for start
// ADD   | acc <= acc + multiplicand through the ALU
// SHF   | multiplicand <<= 1 through the ALU, multiplier >>= 1
// DONE  | product valid, done pulse; ALU already back with EX
module alu_mul_seq
   import wisc_alu_pkg::*;
#(
   parameter int WIDTH      = WISC_WIDTH,   // only 16 is supported
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] mul_a,
   input  logic [WIDTH-1:0] mul_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             mul_z,
   output logic             mul_n,
   input  logic [WIDTH-1:0] ex_a,
   input  logic [WIDTH-1:0] ex_b,
   input  logic [3:0]       ex_ctrl,
   input  logic             ex_flag_we,
   output logic             ex_stall,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   output logic             flag_we
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mc_q, mc_d;
   logic [WIDTH-1:0] mp_q, mp_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic             mul_z_q, mul_z_d;
   logic             mul_n_q, mul_n_d;

   logic [WIDTH-1:0] seq_a, seq_b;
   logic [3:0]       seq_ctrl;
   logic [WIDTH-1:0] nmp;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mc_d      = mc_q;
      mp_d      = mp_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      mul_z_d   = mul_z_q;
      mul_n_d   = mul_n_q;
      seq_a     = '0;
      seq_b     = '0;
      seq_ctrl  = ALU_ADD;
      nmp       = mp_q >> 1;

      case (state_q)
         SEQ_IDLE: begin
            if (start) begin
               acc_d = '0;
               mc_d  = mul_a;
               mp_d  = mul_b;
               cnt_d = '0;
               if (EARLY_EXIT) begin
                  if (mul_b == '0)   state_d = SEQ_DONE;
                  else if (mul_b[0]) state_d = SEQ_ADD;
                  else               state_d = SEQ_SHF;
               end else begin
                  state_d = SEQ_ADD;
               end
            end
         end
         SEQ_ADD: begin
            seq_ctrl = ALU_ADD;
            seq_a    = acc_q;
            // Early-exit mode only enters ADD when mp[0] is set; the fixed-pass
            // mode visits ADD every bit and must add zero for clear bits.
            seq_b    = (EARLY_EXIT || mp_q[0]) ? mc_q : '0;
            acc_d    = alu_result;
            state_d  = SEQ_SHF;
         end
         SEQ_SHF: begin
            seq_ctrl = ALU_SLL;
            seq_a    = mc_q;
            seq_b    = 16'h0001;
            mc_d     = alu_result;
            mp_d     = nmp;
            cnt_d    = cnt_q + 5'd1;
            if (EARLY_EXIT) begin
               if (nmp == '0)   state_d = SEQ_DONE;
               else if (nmp[0]) state_d = SEQ_ADD;
               else             state_d = SEQ_SHF;
            end else begin
               state_d = (cnt_q == 5'd15) ? SEQ_DONE : SEQ_ADD;
            end
         end
         SEQ_DONE: begin
            state_d = SEQ_IDLE;
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase

      // DONE is only ever entered from IDLE or SHF, so this fires once per
      // multiply and the result is already visible while done is high.
      if (state_d == SEQ_DONE && state_q != SEQ_DONE) begin
         product_d = acc_d;
         mul_z_d   = (acc_d == '0);
         mul_n_d   = acc_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= SEQ_IDLE;
         acc_q     <= '0;
         mc_q      <= '0;
         mp_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         mul_z_q   <= 1'b1;
         mul_n_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mc_q      <= mc_d;
         mp_q      <= mp_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         mul_z_q   <= mul_z_d;
         mul_n_q   <= mul_n_d;
      end
   end

   assign busy     = (state_q != SEQ_IDLE);
   assign done     = (state_q == SEQ_DONE);
   assign ex_stall = (state_q == SEQ_ADD) || (state_q == SEQ_SHF);
   assign flag_we  = ex_flag_we & ~ex_stall;
   assign product  = product_q;
   assign mul_z    = mul_z_q;
   assign mul_n    = mul_n_q;

   alu_mul_seq_alu_port_mux #(.WIDTH(WIDTH)) u_port_mux (
      .ex_a     (ex_a),
      .ex_b     (ex_b),
      .ex_ctrl  (ex_ctrl),
      .seq_a    (seq_a),
      .seq_b    (seq_b),
      .seq_ctrl (seq_ctrl),
      .sel_seq  (ex_stall),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_ctrl (alu_ctrl)
   );

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: one early-exit and one fixed-pass instance share the
// stimulus, each driving its own behavioural WISC ALU. Expected results are
// queued when a multiply is started and popped when done is seen.
module tb_alu_mul_seq;
   import wisc_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] mul_a, mul_b;
   logic [15:0] ex_a, ex_b;
   logic [3:0]  ex_ctrl;
   logic        ex_flag_we;

   logic        busy1, done1, mul_z1, mul_n1, ex_stall1, flag_we1;
   logic [15:0] product1, alu_a1, alu_b1, alu_result1;
   logic [3:0]  alu_ctrl1;
   logic        busy0, done0, mul_z0, mul_n0, ex_stall0, flag_we0;
   logic [15:0] product0, alu_a0, alu_b0, alu_result0;
   logic [3:0]  alu_ctrl0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] prod;
      logic        z;
      logic        n;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] op);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_NAND: return ~(a & b);
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[3:0];
         ALU_SRL:  return a >> b[3:0];
         ALU_SRA:  return 16'($signed(a) >>> b[3:0]);
         default:  return 16'h0000;
      endcase
   endfunction

   assign alu_result1 = alu_model(alu_a1, alu_b1, alu_ctrl1);
   assign alu_result0 = alu_model(alu_a0, alu_b0, alu_ctrl0);

   alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .mul_a(mul_a), .mul_b(mul_b),
      .busy(busy1), .done(done1), .product(product1), .mul_z(mul_z1), .mul_n(mul_n1),
      .ex_a(ex_a), .ex_b(ex_b), .ex_ctrl(ex_ctrl), .ex_flag_we(ex_flag_we),
      .ex_stall(ex_stall1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_ctrl1),
      .alu_result(alu_result1), .flag_we(flag_we1)
   );

   alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .mul_a(mul_a), .mul_b(mul_b),
      .busy(busy0), .done(done0), .product(product0), .mul_z(mul_z0), .mul_n(mul_n0),
      .ex_a(ex_a), .ex_b(ex_b), .ex_ctrl(ex_ctrl), .ex_flag_we(ex_flag_we),
      .ex_stall(ex_stall0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_ctrl(alu_ctrl0),
      .alu_result(alu_result0), .flag_we(flag_we0)
   );

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chkint(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Early-exit latency: one cycle to start, one per set bit (ADD), one per
   // bit position up to and including the top set bit (SHF).
   function automatic int lat_ee(input logic [15:0] b);
      int pc = 0;
      int hi = -1;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) begin
            pc++;
            hi = i;
         end
      end
      return (b == 16'h0000) ? 1 : 1 + pc + hi + 1;
   endfunction

   task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit extra);
      logic [15:0] p;
      exp_t        e;
      int          cyc;
      bit          got1, got0, stall_seen;
      p = a * b;
      @(negedge clk);
      mul_a      = a;
      mul_b      = b;
      start      = 1'b1;
      ex_flag_we = 1'b1;
      ex_ctrl    = ALU_XOR;
      ex_a       = 16'h00F0;
      ex_b       = 16'h0F0F;
      e.prod = p; e.z = (p == 16'h0000); e.n = p[15];
      e.cyc = lat_ee(b);
      q1.push_back(e);
      e.cyc = 33;
      q0.push_back(e);
      #1;
      chk16("start_cycle_ex_result", alu_result1, 16'h0FFF);
      cyc = 0; got1 = 0; got0 = 0; stall_seen = 0;
      while (cyc < 45 && !(got1 && got0)) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         start = extra && (cyc == 1 || cyc == 5);
         mul_a = start ? 16'hFFFF : a;
         mul_b = start ? 16'hFFFF : b;
         if (ex_stall1) begin
            stall_seen = 1;
            chk1("stall_flag_we", flag_we1, 1'b0);
            chk1("stall_ctrl", (alu_ctrl1 == ALU_ADD) || (alu_ctrl1 == ALU_SLL), 1'b1);
         end
         if (done1) begin
            chk1("ee_single_done", got1, 1'b0);
            got1 = 1;
            if (q1.size() > 0) begin
               e = q1.pop_front();
               chk16("ee_product", product1, e.prod);
               chk1("ee_mul_z", mul_z1, e.z);
               chk1("ee_mul_n", mul_n1, e.n);
               chkint("ee_latency", cyc, e.cyc);
            end
         end
         if (done0) begin
            chk1("fx_single_done", got0, 1'b0);
            got0 = 1;
            if (q0.size() > 0) begin
               e = q0.pop_front();
               chk16("fx_product", product0, e.prod);
               chk1("fx_mul_z", mul_z0, e.z);
               chk1("fx_mul_n", mul_n0, e.n);
               chkint("fx_latency", cyc, e.cyc);
            end
         end
      end
      start = 1'b0;
      chk1("ee_done_seen", got1, 1'b1);
      chk1("fx_done_seen", got0, 1'b1);
      if (b == 16'h0000) chk1("ee_no_stall_b0", stall_seen, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk1("ee_idle_after", busy1, 1'b0);
      chk16("ee_product_held", product1, p);
      chk16("fx_product_held", product0, p);
   endtask

   initial begin
      int dones;
      logic [15:0] sa, sb;
      rst_n = 1'b0; start = 1'b0; mul_a = '0; mul_b = '0;
      ex_a = '0; ex_b = '0; ex_ctrl = ALU_ADD; ex_flag_we = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("rst_busy", busy1, 1'b0);
      chk1("rst_done", done1, 1'b0);
      chk16("rst_product", product1, 16'h0000);
      chk1("rst_mul_z", mul_z1, 1'b1);
      chk1("rst_mul_n", mul_n1, 1'b0);
      chk1("rst_ex_stall", ex_stall1, 1'b0);
      chk1("rst_fx_mul_z", mul_z0, 1'b1);
      rst_n = 1'b1;

      // EX passthrough while IDLE.
      @(negedge clk);
      ex_ctrl = ALU_SUB; ex_a = 16'd9; ex_b = 16'd4; ex_flag_we = 1'b1;
      #1;
      chk16("idle_sub_result", alu_result1, 16'd5);
      chk1("idle_flag_we1", flag_we1, 1'b1);
      ex_flag_we = 1'b0;
      #1;
      chk1("idle_flag_we0", flag_we1, 1'b0);
      chk16("idle_fx_sub_result", alu_result0, 16'd5);

      run_mul(16'd3, 16'd5, 1'b0);
      run_mul(16'h1234, 16'h0000, 1'b0);
      run_mul(16'hFFFF, 16'hFFFF, 1'b0);
      run_mul(16'd7, 16'h0000, 1'b0);
      run_mul(16'h8001, 16'h0003, 1'b0);
      run_mul(16'd3, 16'd5, 1'b1);

      // Reset in the middle of a long multiply: no done, product cleared.
      run_mul(16'h0101, 16'h00F3, 1'b0);
      @(negedge clk);
      mul_a = 16'hFFFF; mul_b = 16'hFFFF; start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk1("midrst_busy", busy1, 1'b0);
      chk1("midrst_fx_busy", busy0, 1'b0);
      chk1("midrst_done", done1, 1'b0);
      chk16("midrst_product", product1, 16'h0000);
      chk16("midrst_fx_product", product0, 16'h0000);
      chk1("midrst_mul_z", mul_z1, 1'b1);
      chk1("midrst_stall", ex_stall1, 1'b0);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done1 || done0) dones++;
      end
      chkint("midrst_no_done", dones, 0);
      run_mul(16'd2, 16'd3, 1'b0);

      sa = 16'h0000; sb = 16'h0001;
      for (int i = 0; i < 150; i++) begin
         run_mul(sa, sb, 1'b0);
         sa = sa + 16'd31 * 16'd211;
         sb = sb + 16'd73 * 16'd137;
      end

      chkint("q1_drained", q1.size(), 0);
      chkint("q0_drained", q0.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
